// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, handles
// load-use stalls, branch flushes and halt draining ahead of the decoder.
module if_stage #(
    parameter int unsigned PC_W         = 9,
    parameter int unsigned INS_W        = 32,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic [6:0]       ifid_opcode,
    output logic             ifid_valid,
    output logic             halted
);

    // Counter only needs to hold DRAIN_CYCLES-1.
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // addi x0,x0,0; an all-zero word would decode as halt, so bubbles use this.
    localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and pipeline registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= PC_W'(RESET_PC);
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: branch beats stall beats halt beats a normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    pc_d         = branch_target;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt && ifid_valid_q) begin
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    cnt_d        = CNT_W'(DRAIN_CYCLES - 1);
                    state_d      = S_DRAIN;
                end else begin
                    ifid_instr_d = imem_rdata;
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + PC_W'(4);
                end
            end
            S_DRAIN: begin
                ifid_instr_d = NOP;
                ifid_valid_d = 1'b0;
                if (branch_taken) begin
                    // An older branch in EX invalidates the halting instruction.
                    pc_d    = branch_target;
                    state_d = S_RUN;
                end else if (cnt_q == '0) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALTED: begin
                ifid_instr_d = NOP;
                ifid_valid_d = 1'b0;
                halted_d     = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs come straight from registers.
    assign imem_addr   = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_opcode = ifid_instr_q[6:0];
    assign ifid_valid  = ifid_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic,
// compared against a cycle-level behavioural model.
module tb_if_stage;

    localparam int unsigned PC_W         = 9;
    localparam int unsigned INS_W        = 32;
    localparam int unsigned RESET_PC     = 0;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int          PC_MOD       = 1 << PC_W;
    localparam logic [31:0] NOP_W        = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_target;
    logic             halt;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic [PC_W-1:0]  ifid_pc;
    logic [INS_W-1:0] ifid_instr;
    logic [6:0]       ifid_opcode;
    logic             ifid_valid;
    logic             halted;
    logic             use_hash;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: 0 = fetching, 1 = draining, 2 = stopped.
    int          m_pc, m_ipc, m_mode, m_left;
    logic [31:0] m_ins;
    logic        m_val, m_halted;

    if_stage #(
        .PC_W(PC_W), .INS_W(INS_W), .RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_opcode(ifid_opcode), .ifid_valid(ifid_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hashf(input logic [PC_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    function automatic logic [31:0] memf(input logic [PC_W-1:0] a, input logic h);
        return h ? hashf(a) : 32'(a);
    endfunction

    // Combinational instruction memory.
    assign imem_rdata = memf(imem_addr, use_hash);

    task automatic model_reset();
        m_pc = int'(RESET_PC); m_ipc = 0; m_ins = NOP_W; m_val = 1'b0;
        m_halted = 1'b0; m_mode = 0; m_left = 0;
    endtask

    task automatic bubble();
        m_ins = NOP_W; m_val = 1'b0;
    endtask

    // One clock of the reference behaviour, evaluated from pre-edge inputs.
    task automatic model_step(input logic s, input logic b, input int tgt, input logic h);
        logic [31:0] word;
        word = memf(PC_W'(m_pc), use_hash);
        if (m_mode == 2) begin
            bubble();
        end else if (m_mode == 1) begin
            bubble();
            if (b) begin
                m_pc = tgt; m_mode = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = 2; m_halted = 1'b1;
                end
            end
        end else if (b) begin
            m_pc = tgt; bubble();
        end else if (s) begin
            m_pc = m_pc;
        end else if (h && m_val) begin
            bubble(); m_mode = 1; m_left = DRAIN_CYCLES;
        end else begin
            m_ins = word; m_ipc = m_pc; m_val = 1'b1;
            m_pc = (m_pc + 4) % PC_MOD;
        end
    endtask

    task automatic check_all(input string tag);
        n_assert++;
        assert (imem_addr === PC_W'(m_pc)) else begin
            n_fail++; $error("FAIL %s imem_addr observed=%h expected=%h", tag, imem_addr, PC_W'(m_pc));
        end
        n_assert++;
        assert (ifid_pc === PC_W'(m_ipc)) else begin
            n_fail++; $error("FAIL %s ifid_pc observed=%h expected=%h", tag, ifid_pc, PC_W'(m_ipc));
        end
        n_assert++;
        assert (ifid_instr === m_ins) else begin
            n_fail++; $error("FAIL %s ifid_instr observed=%h expected=%h", tag, ifid_instr, m_ins);
        end
        n_assert++;
        assert (ifid_opcode === m_ins[6:0]) else begin
            n_fail++; $error("FAIL %s ifid_opcode observed=%h expected=%h", tag, ifid_opcode, m_ins[6:0]);
        end
        n_assert++;
        assert (ifid_valid === m_val) else begin
            n_fail++; $error("FAIL %s ifid_valid observed=%b expected=%b", tag, ifid_valid, m_val);
        end
        n_assert++;
        assert (halted === m_halted) else begin
            n_fail++; $error("FAIL %s halted observed=%b expected=%b", tag, halted, m_halted);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input logic s, input logic b, input int tgt, input logic h);
        stall = s; branch_taken = b; branch_target = PC_W'(tgt); halt = h;
        model_step(s, b, tgt, h);
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        #1;
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        use_hash = 1'b0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
        @(negedge clk);
        do_reset("reset");
        n_assert++;
        assert (ifid_opcode === 7'h13) else begin
            n_fail++; $error("FAIL reset_opcode observed=%h expected=%h", ifid_opcode, 7'h13);
        end

        // Sequential fetch 0,4 then a two-cycle stall with PC at 8.
        step("seq0", 0, 0, 0, 0);
        step("seq4", 0, 0, 0, 0);
        step("stall1", 1, 0, 0, 0);
        step("stall2", 1, 0, 0, 0);
        step("seq8", 0, 0, 0, 0);
        step("seq12", 0, 0, 0, 0);

        // Branch overrides a simultaneous stall at PC 0x10.
        step("br_stall", 1, 1, 'h40, 0);
        step("br_fetch", 0, 0, 0, 0);

        // Halt against a bubble is ignored.
        step("br_1c", 0, 1, 'h1C, 0);
        step("halt_bub", 0, 0, 0, 1);

        // Halt with PC at 0x20, drain, then stay stopped through pulses.
        step("halt_go", 0, 0, 0, 1);
        step("drain1", 1, 0, 0, 0);
        step("drain2", 0, 0, 0, 0);
        step("drain3", 0, 0, 0, 0);
        n_assert++;
        assert (halted === 1'b1 && imem_addr === PC_W'('h20)) else begin
            n_fail++; $error("FAIL halted_4th observed=%b/%h expected=1/020", halted, imem_addr);
        end
        step("hold_stall", 1, 0, 0, 0);
        step("hold_br", 0, 1, 'h80, 0);
        step("hold_halt", 0, 0, 0, 1);

        // Branch during drain cancels the halt.
        do_reset("reset2");
        step("r2_f0", 0, 0, 0, 0);
        step("r2_halt", 0, 0, 0, 1);
        step("r2_dr1", 0, 0, 0, 0);
        step("r2_br", 0, 1, 'h80, 0);
        step("r2_f80", 0, 0, 0, 0);
        step("r2_f84", 1, 0, 0, 0);
        step("r2_more", 0, 0, 0, 0);

        // PC wraps from 0x1FC to 0.
        step("wrap_br", 0, 1, 'h1FC, 0);
        step("wrap_1fc", 0, 0, 0, 0);
        step("wrap_0", 0, 0, 0, 0);
        n_assert++;
        assert (ifid_pc === PC_W'(0) && imem_addr === PC_W'(4)) else begin
            n_fail++; $error("FAIL wrap observed=%h/%h expected=000/004", ifid_pc, imem_addr);
        end

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        model_step(0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model with a scrambled memory image.
        use_hash = 1'b1;
        do_reset("rand_reset");
        for (int i = 0; i < 600; i++) begin
            logic s, b, h;
            int   t;
            s = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 24) == 0);
            t = int'($urandom_range(0, PC_MOD / 4 - 1)) * 4;
            step("rand", s, b, t, h);
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset("rand_reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
